// File: rtl/lsu32_pkg.sv
// Shared types and constants for the lsu32_rmw load/store initiator.
// Size codes, exception codes, FSM states and the alignment rule live here.
package lsu32_pkg;

  // Highest valid byte index of the attached data memory.
  localparam int unsigned ADDR_LIMIT = 1048575;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    EXC_NONE       = 2'd0,
    EXC_MISALIGNED = 2'd1,
    EXC_ACCESS     = 2'd2
  } exc_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Size code 3 has no legal alignment and always reports misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SIZE_H) && offset[0]) ||
           ((size == SIZE_W) && (offset != 2'd0)) ||
           (size == 2'd3);
  endfunction

endpackage

// File: rtl/lsu32_rmw_if.sv
// Core request/response and data-memory port bundle for lsu32_rmw.
// slave is the load/store unit's view; master is the core-plus-memory side.
interface lsu32_rmw_if;
  logic        in_req_valid;
  logic        out_req_ready;
  logic        in_req_write;
  logic [1:0]  in_req_size;
  logic        in_req_signed;
  logic [31:0] in_req_address;
  logic [31:0] in_req_data;

  logic        out_resp_valid;
  logic        in_resp_ready;
  logic [31:0] out_resp_data;
  logic [1:0]  out_resp_exception;

  logic [31:0] out_mem_read_address;
  logic [31:0] out_mem_write_address;
  logic        out_mem_write_enable;
  logic [31:0] out_mem_write_data;
  logic [31:0] in_mem_read_data;
  logic        in_mem_read_exception;
  logic        in_mem_write_exception;

  modport slave (
    input  in_req_valid, in_req_write, in_req_size, in_req_signed,
           in_req_address, in_req_data, in_resp_ready,
           in_mem_read_data, in_mem_read_exception, in_mem_write_exception,
    output out_req_ready, out_resp_valid, out_resp_data, out_resp_exception,
           out_mem_read_address, out_mem_write_address,
           out_mem_write_enable, out_mem_write_data
  );

  modport master (
    output in_req_valid, in_req_write, in_req_size, in_req_signed,
           in_req_address, in_req_data, in_resp_ready,
           in_mem_read_data, in_mem_read_exception, in_mem_write_exception,
    input  out_req_ready, out_resp_valid, out_resp_data, out_resp_exception,
           out_mem_read_address, out_mem_write_address,
           out_mem_write_enable, out_mem_write_data
  );
endinterface

// File: rtl/lsu32_byte_lanes.sv
// Combinational lane logic: store merge into a memory word and
// load extraction with sign/zero extension.
module lsu32_byte_lanes
  import lsu32_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    merged = word;
    case (size)
      SIZE_B:  merged[{offset, 3'b000} +: 8]        = store_data[7:0];
      SIZE_H:  merged[{offset[1], 4'b0000} +: 16]   = store_data[15:0];
      default: merged                               = store_data;
    endcase
  end

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (size)
      SIZE_B:  load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SIZE_H:  load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu32_rmw.sv
// Load/store initiator: one request in flight, full-word memory accesses,
// read-modify-write for byte and half-word stores.
module lsu32_rmw
  import lsu32_pkg::*;
(
  input logic         CLK,
  input logic         RESET,
  lsu32_rmw_if.slave  bus
);

  state_e      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [31:0] data_q;
  logic [31:0] mem_addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  exc_e        resp_exc_q;

  logic [31:0] merged;
  logic [31:0] load_data;

  lsu32_byte_lanes u_lanes (
    .word       (bus.in_mem_read_data),
    .store_data (data_q),
    .offset     (off_q),
    .size       (size_q),
    .is_signed  (signed_q),
    .merged     (merged),
    .load_data  (load_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      off_q        <= '0;
      size_q       <= SIZE_B;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      data_q       <= '0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_exc_q   <= EXC_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_req_valid) begin
            off_q    <= bus.in_req_address[1:0];
            size_q   <= bus.in_req_size;
            signed_q <= bus.in_req_signed;
            write_q  <= bus.in_req_write;
            data_q   <= bus.in_req_data;
            if (is_misaligned(bus.in_req_size, bus.in_req_address[1:0])) begin
              // No memory access: the address outputs keep their last value.
              resp_valid_q <= 1'b1;
              resp_data_q  <= '0;
              resp_exc_q   <= EXC_MISALIGNED;
              state        <= RESP;
            end else begin
              mem_addr_q <= {bus.in_req_address[31:2], 2'b00};
              if (bus.in_req_write && (bus.in_req_size == SIZE_W)) begin
                wdata_q <= bus.in_req_data;
                state   <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end

        READ: begin
          if (bus.in_mem_read_exception) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_exc_q   <= EXC_ACCESS;
            state        <= RESP;
          end else if (write_q) begin
            wdata_q <= merged;
            state   <= WRITE;
          end else begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= load_data;
            resp_exc_q   <= EXC_NONE;
            state        <= RESP;
          end
        end

        WRITE: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= '0;
          resp_exc_q   <= bus.in_mem_write_exception ? EXC_ACCESS : EXC_NONE;
          state        <= RESP;
        end

        RESP: begin
          if (bus.in_resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Ready and the write strobe depend on same-cycle inputs (RESET, the
  // memory's write exception), so they are decoded from the registered state.
  assign bus.out_req_ready         = (state == IDLE) && !RESET;
  assign bus.out_mem_write_enable  = (state == WRITE) && !bus.in_mem_write_exception && !RESET;
  assign bus.out_mem_read_address  = mem_addr_q;
  assign bus.out_mem_write_address = mem_addr_q;
  assign bus.out_mem_write_data    = wdata_q;
  assign bus.out_resp_valid        = resp_valid_q;
  assign bus.out_resp_data         = resp_data_q;
  assign bus.out_resp_exception    = resp_exc_q;

endmodule

// File: tb/tb_lsu32_rmw.sv
// Scoreboard bench for lsu32_rmw: directed requests push expected responses
// and writes; a negedge monitor pops and compares them.
module tb_lsu32_rmw;
  import lsu32_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  lsu32_rmw_if bus();

  lsu32_rmw dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  exc;
    int unsigned due;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t exp_q[$];
  wr_t   wr_q[$];
  resp_t cur;
  wr_t   wcur;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned acc_a, acc_b, acc_r, hs_cyc;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  logic        force_rexc = 1'b0;
  logic        force_wexc = 1'b0;
  logic        prev_valid = 1'b0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (bus.out_mem_write_enable)
      mem[bus.out_mem_write_address[11:2]] <= bus.out_mem_write_data;
  end

  assign bus.in_mem_read_data       = mem[bus.out_mem_read_address[11:2]];
  assign bus.in_mem_read_exception  = force_rexc || (bus.out_mem_read_address > ADDR_LIMIT);
  assign bus.in_mem_write_exception = force_wexc || (bus.out_mem_write_address > ADDR_LIMIT);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (bus.out_mem_write_enable) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write_strobe", {31'b0, bus.out_mem_write_enable}, 32'd0);
      end else begin
        wcur = wr_q.pop_front();
        check("write_addr", bus.out_mem_write_address, wcur.addr);
        check("write_data", bus.out_mem_write_data, wcur.data);
        check("write_addr_eq_read_addr", bus.out_mem_write_address, bus.out_mem_read_address);
      end
    end
    if (bus.out_resp_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'b0, bus.out_resp_valid}, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("resp_data", bus.out_resp_data, cur.data);
        check("resp_exc", {30'b0, bus.out_resp_exception}, {30'b0, cur.exc});
        check("resp_latency", cyc, cur.due);
      end
    end else if (bus.out_resp_valid) begin
      check("hold_data", bus.out_resp_data, cur.data);
      check("hold_exc", {30'b0, bus.out_resp_exception}, {30'b0, cur.exc});
    end
    prev_valid = bus.out_resp_valid;
  end

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_data, input logic [1:0] exp_exc,
                       input int unsigned lat, input bit track,
                       output int unsigned acc);
    int unsigned budget = 0;
    resp_t r;
    @(negedge CLK);
    bus.in_req_valid   = 1'b1;
    bus.in_req_write   = wr;
    bus.in_req_size    = sz;
    bus.in_req_signed  = sg;
    bus.in_req_address = addr;
    bus.in_req_data    = data;
    while (!bus.out_req_ready && budget < 50) begin
      @(negedge CLK);
      budget++;
    end
    acc = cyc;
    if (!bus.out_req_ready) begin
      check("accept_timeout", {31'b0, bus.out_req_ready}, 32'd1);
    end else if (track) begin
      r.data = exp_data;
      r.exc  = exp_exc;
      r.due  = cyc + lat;
      exp_q.push_back(r);
    end
    @(negedge CLK);
    bus.in_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned b = 0;
    do begin
      @(negedge CLK);
      b++;
    end while ((exp_q.size() != 0 || bus.out_resp_valid || !bus.out_req_ready) && b < 60);
    if (b >= 60) check("idle_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wr_q.push_back(w);
  endtask

  task automatic req(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_data, input logic [1:0] exp_exc,
                     input int unsigned lat);
    int unsigned acc;
    issue(wr, sz, sg, addr, data, exp_data, exp_exc, lat, 1'b1, acc);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_req_valid   = 1'b0;
    bus.in_req_write   = 1'b0;
    bus.in_req_size    = SIZE_B;
    bus.in_req_signed  = 1'b0;
    bus.in_req_address = '0;
    bus.in_req_data    = '0;
    bus.in_resp_ready  = 1'b1;

    @(negedge CLK);
    pl_en = 1'b1; pl_idx = 10'h040; pl_val = 32'h1122_3344;
    @(negedge CLK);
    pl_idx = 10'h080; pl_val = 32'h8001_7FFF;
    @(negedge CLK);
    pl_en = 1'b0;

    check("rst_req_ready", {31'b0, bus.out_req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, bus.out_resp_valid}, 32'd0);
    check("rst_write_enable", {31'b0, bus.out_mem_write_enable}, 32'd0);
    check("rst_read_addr", bus.out_mem_read_address, 32'd0);
    check("rst_write_addr", bus.out_mem_write_address, 32'd0);
    check("rst_write_data", bus.out_mem_write_data, 32'd0);
    check("rst_resp_data", bus.out_resp_data, 32'd0);
    check("rst_resp_exc", {30'b0, bus.out_resp_exception}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", {31'b0, bus.out_req_ready}, 32'd1);

    expect_write(32'h100, 32'h11AB_3344);
    req(1'b1, SIZE_B, 1'b0, 32'h102, 32'h0000_00AB, 32'h0, EXC_NONE, 3);
    req(1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 32'h11AB_3344, EXC_NONE, 2);
    req(1'b0, SIZE_H, 1'b1, 32'h202, 32'h0, 32'hFFFF_8001, EXC_NONE, 2);
    req(1'b0, SIZE_H, 1'b0, 32'h202, 32'h0, 32'h0000_8001, EXC_NONE, 2);
    req(1'b0, SIZE_H, 1'b0, 32'h200, 32'h0, 32'h0000_7FFF, EXC_NONE, 2);
    req(1'b0, SIZE_B, 1'b1, 32'h201, 32'h0, 32'h0000_007F, EXC_NONE, 2);
    req(1'b0, SIZE_B, 1'b1, 32'h203, 32'h0, 32'hFFFF_FF80, EXC_NONE, 2);

    expect_write(32'h100, 32'hBEEF_3344);
    req(1'b1, SIZE_H, 1'b0, 32'h102, 32'h1234_BEEF, 32'h0, EXC_NONE, 3);
    req(1'b0, SIZE_B, 1'b0, 32'h103, 32'h0, 32'h0000_00BE, EXC_NONE, 2);
    req(1'b0, SIZE_B, 1'b1, 32'h103, 32'h0, 32'hFFFF_FFBE, EXC_NONE, 2);

    expect_write(32'h104, 32'hCAFE_F00D);
    req(1'b1, SIZE_W, 1'b0, 32'h104, 32'hCAFE_F00D, 32'h0, EXC_NONE, 2);
    req(1'b0, SIZE_W, 1'b0, 32'h104, 32'h0, 32'hCAFE_F00D, EXC_NONE, 2);

    req(1'b0, SIZE_W, 1'b0, 32'h101, 32'h0, 32'h0, EXC_MISALIGNED, 1);
    check("misaligned_read_addr_kept", bus.out_mem_read_address, 32'h104);
    check("misaligned_write_addr_kept", bus.out_mem_write_address, 32'h104);
    req(1'b1, SIZE_H, 1'b0, 32'h103, 32'h0000_FFFF, 32'h0, EXC_MISALIGNED, 1);
    req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, EXC_MISALIGNED, 1);

    force_wexc = 1'b1;
    req(1'b1, SIZE_W, 1'b0, 32'h000F_FFFC, 32'hDEAD_BEEF, 32'h0, EXC_ACCESS, 2);
    check("oor_store_addr", bus.out_mem_read_address, 32'h000F_FFFC);
    force_wexc = 1'b0;
    force_rexc = 1'b1;
    req(1'b0, SIZE_B, 1'b1, 32'h100, 32'h0, 32'h0, EXC_ACCESS, 2);
    req(1'b1, SIZE_H, 1'b0, 32'h200, 32'h0000_5555, 32'h0, EXC_ACCESS, 2);
    force_rexc = 1'b0;
    req(1'b0, SIZE_W, 1'b0, 32'h200, 32'h0, 32'h8001_7FFF, EXC_NONE, 2);

    bus.in_resp_ready = 1'b0;
    issue(1'b0, SIZE_W, 1'b0, 32'h200, 32'h0, 32'h8001_7FFF, EXC_NONE, 2, 1'b1, acc_a);
    fork
      issue(1'b0, SIZE_H, 1'b1, 32'h200, 32'h0, 32'h0000_7FFF, EXC_NONE, 2, 1'b1, acc_b);
      begin
        repeat (5) begin
          @(negedge CLK);
          check("busy_ready_low", {31'b0, bus.out_req_ready}, 32'd0);
        end
        bus.in_resp_ready = 1'b1;
        hs_cyc = cyc;
      end
    join
    check("second_accept_cycle", acc_b, hs_cyc + 1);
    wait_idle();

    issue(1'b1, SIZE_B, 1'b0, 32'h100, 32'h0000_0055, 32'h0, EXC_NONE, 3, 1'b0, acc_r);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("rst_mid_no_write", {31'b0, bus.out_mem_write_enable}, 32'd0);
    @(negedge CLK);
    check("rst_mid_ready", {31'b0, bus.out_req_ready}, 32'd1);
    repeat (5) @(negedge CLK);
    check("rst_mid_mem_unchanged", mem[10'h040], 32'hBEEF_3344);
    req(1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 32'hBEEF_3344, EXC_NONE, 2);

    check("resp_queue_drained", exp_q.size(), 32'd0);
    check("write_queue_drained", wr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
